// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//   Time-multiplexed 7-segment display driver. Each digit is selected in turn
//   for SCAN_DIV clock cycles. The digit drawn is taken from a shadow register
//   that is loaded from `value` on a `load` strobe. Leading-zero blanking is
//   optional.
//
//   Parameters
//     NUM_DIGITS  number of multiplexed digits (1..8)
//     SCAN_DIV    clock cycles each digit stays selected (2..65535)
//
//   Ports
//     clk         single clock; all state updates on the rising edge
//     rst         asynchronous, active-high reset
//     en          1 = scanning; 0 = scanning frozen and display dark
//     load        one-cycle strobe that captures `value` into the shadow register
//     value       packed nibbles; digit i = value[4i+3:4i]; digit 0 = rightmost
//     lzb         1 = blank leading zeros (digit 0 is never blanked)
//     seg         active-high segments {a,b,c,d,e,f,g}
//     dig_sel     active-high one-hot digit enable
//     frame_done  one-cycle pulse after the scan of all digits completes
//
//   Configuration
//     SEG_HEX_EN  when defined, codes 10..15 are drawn as A b C d E F.
//                 When undefined, those codes are drawn dark but still count
//                 as non-zero for blanking.
// ---------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    lzb,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]        presc;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow;

  logic                    terminal;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic [NUM_DIGITS:0]     zero_from;
  logic [NUM_DIGITS-1:0]   sel_next;
  logic [6:0]              seg_next;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
`ifdef SEG_HEX_EN
      4'd10:   decode = 7'b1110111;
      4'd11:   decode = 7'b0011111;
      4'd12:   decode = 7'b1001110;
      4'd13:   decode = 7'b0111101;
      4'd14:   decode = 7'b1001111;
      4'd15:   decode = 7'b1000111;
`endif
      default: decode = 7'b0000000;
    endcase
  endfunction

  assign terminal = (presc == PRE_LAST);

  // zero_from[i] is set when digits i..NUM_DIGITS-1 are all zero. A
  // selected digit above position 0 is blanked when this holds.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    zero_from             = '0;
    zero_from[NUM_DIGITS] = 1'b1;
    cur_nib               = 4'd0;
    cur_blank             = 1'b0;
    sel_next              = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] & (shadow[4*i +: 4] == 4'd0);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib     = shadow[4*i +: 4];
        cur_blank   = lzb && (i != 0) && zero_from[i];
        sel_next[i] = 1'b1;
      end
    end
    seg_next = (en && !cur_blank) ? decode(cur_nib) : 7'b0000000;
    if (!en) sel_next = '0;
  end

  // The shadow register is the display's data store. It is cleared on reset
  // so that a fresh display never shows stale digits.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values and the order of statements does not matter.
    if (rst) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= value;
    end
  end

  // The prescaler and the digit index advance only while enabled. The index
  // changes on the same edge where the prescaler wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (en) begin
      if (terminal) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Outputs are registered from the pre-edge index and shadow, which gives
  // one cycle of latency. frame_done is high for the cycle that follows the
  // edge where the index wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= 7'b0000000;
      dig_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_next;
      dig_sel    <= sel_next;
      frame_done <= en && terminal && (idx == IDX_LAST);
    end
  end

endmodule
